jtag_report_scheduler: RTL and testbench

- Owns the single debug_bridge_jtag port and shares its host-bound (write) direction between up to NSRC report sources using round-robin packet arbitration.
- Drives the host-to-FPGA (read) direction as a continuous command poll and delivers received command words to the command decoder.
- Replaces the per-module jtag_idx/jtag_wr plumbing, so that framecount, status and other blocks can each report independently.

---
 rtl/jtag_report_scheduler.sv | 121 ++++++++++++
 tb/tb_jtag_report_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_report_scheduler.sv
// Shares the debug_bridge_jtag host-bound direction among NSRC report sources (round-robin, whole packets)
// and polls the host-to-FPGA direction for command words; each transfer waits indefinitely on bridge_ack.
module jtag_report_scheduler #(
    parameter int          NSRC    = 4,
    parameter int          LENW    = 8,
    parameter logic [7:0]  HDR_TAG = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NSRC-1:0]      src_req,
    input  logic [NSRC*LENW-1:0] src_len,
    input  logic [NSRC*32-1:0]   src_d,
    output logic [NSRC-1:0]      src_grant,
    output logic [LENW-1:0]      src_idx,
    output logic [NSRC-1:0]      src_done,
    output logic [31:0]          bridge_d,
    input  logic [31:0]          bridge_q,
    output logic                 bridge_req,
    output logic                 bridge_wr,
    input  logic                 bridge_ack,
    output logic                 cmd_valid,
    output logic [31:0]          cmd_q
);

    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

    state_t          state;
    logic [3:0]      ptr;
    logic [3:0]      gnt_id;
    logic [LENW-1:0] len_q;

    logic [3:0]      pick_id;
    logic            pick_vld;
    logic [LENW-1:0] pick_len;
    logic [31:0]     cur_word;

    // Scan downwards so the nearest requester after the pointer wins.
    always_comb begin
        pick_id  = '0;
        pick_vld = 1'b0;
        for (int i = NSRC; i >= 1; i--) begin
            int c;
            c = (int'(ptr) + i) % NSRC;
            if (src_req[c]) begin
                pick_id  = 4'(c);
                pick_vld = 1'b1;
            end
        end
    end

    assign pick_len = src_len[pick_id*LENW +: LENW];
    assign cur_word = src_d[gnt_id*32 +: 32];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= 4'(NSRC-1);
            gnt_id     <= '0;
            len_q      <= '0;
            src_grant  <= '0;
            src_idx    <= '0;
            src_done   <= '0;
            bridge_d   <= '0;
            bridge_req <= 1'b0;
            bridge_wr  <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_q      <= '0;
        end else begin
            // One low cycle after every ack marks the boundary where wr/d may change.
            bridge_req <= !bridge_ack;
            cmd_valid  <= 1'b0;
            src_done   <= '0;
            case (state)
                IDLE: begin
                    bridge_wr <= 1'b0;
                    if (bridge_ack) begin
                        cmd_q     <= bridge_q;
                        cmd_valid <= 1'b1;
                    end else if (pick_vld && !bridge_req) begin
                        gnt_id    <= pick_id;
                        ptr       <= pick_id;
                        len_q     <= pick_len;
                        src_grant <= NSRC'(1) << pick_id;
                        bridge_d  <= {HDR_TAG, 4'b0, pick_id, 16'(pick_len)};
                        bridge_wr <= 1'b1;
                        state     <= HEADER;
                    end
                end
                HEADER: begin
                    if (bridge_ack) begin
                        if (len_q == '0) begin
                            src_done  <= src_grant;
                            src_grant <= '0;
                            bridge_wr <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            src_idx <= '0;
                            state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (bridge_ack) begin
                        if (src_idx == len_q - LENW'(1)) begin
                            src_done  <= src_grant;
                            src_grant <= '0;
                            bridge_wr <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            src_idx <= src_idx + LENW'(1);
                        end
                    end else if (!bridge_req) begin
                        bridge_d <= cur_word;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_report_scheduler.sv
// Directed bench for jtag_report_scheduler: table of single packets plus poll, round-robin,
// mid-packet reset and stall sequences, with the bench acting as the JTAG bridge.
module tb_jtag_report_scheduler;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   src_req;
    logic [31:0]  src_len;
    logic [127:0] src_d;
    logic [3:0]   src_grant;
    logic [7:0]   src_idx;
    logic [3:0]   src_done;
    logic [31:0]  bridge_d;
    logic [31:0]  bridge_q;
    logic         bridge_req;
    logic         bridge_wr;
    logic         bridge_ack;
    logic         cmd_valid;
    logic [31:0]  cmd_q;

    logic [31:0]  base_arr [4];
    int           total = 0;
    int           bad   = 0;

    always #5 clk = ~clk;

    jtag_report_scheduler #(.NSRC(4), .LENW(8), .HDR_TAG(8'hA5)) dut (
        .clk(clk), .reset_n(reset_n), .src_req(src_req), .src_len(src_len), .src_d(src_d),
        .src_grant(src_grant), .src_idx(src_idx), .src_done(src_done),
        .bridge_d(bridge_d), .bridge_q(bridge_q), .bridge_req(bridge_req), .bridge_wr(bridge_wr),
        .bridge_ack(bridge_ack), .cmd_valid(cmd_valid), .cmd_q(cmd_q)
    );

    // Each source presents base + index as its payload word.
    always_comb begin
        src_d = '0;
        for (int s = 0; s < 4; s++) src_d[s*32 +: 32] = base_arr[s] + 32'(src_idx);
    end

    typedef struct {
        int          src;
        logic [7:0]  len;
        logic [31:0] base;
        logic [31:0] hdr;
    } vec_t;
    vec_t tbl [5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Waits for a pending transfer, captures it and acks it; returns at the negedge after the ack edge.
    task automatic ack_xfer(input logic [31:0] q, output logic [31:0] d, output logic wr);
        int n;
        n  = 0;
        d  = '0;
        wr = 1'b0;
        while (bridge_req !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bridge_req !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL req_timeout: got bridge_req=%b expected 1", bridge_req);
        end else begin
            d          = bridge_d;
            wr         = bridge_wr;
            bridge_q   = q;
            bridge_ack = 1'b1;
            @(negedge clk);
            bridge_ack = 1'b0;
        end
    endtask

    task automatic get_header(input logic [31:0] exp_hdr);
        logic [31:0] d;
        logic        wr;
        wr = 1'b0;
        for (int k = 0; k < 6 && !wr; k++) ack_xfer(32'h0, d, wr);
        check("hdr_wr", 32'(wr), 32'd1);
        check("hdr", d, exp_hdr);
    endtask

    task automatic send_data(input int s, input int len, input logic [31:0] base);
        logic [31:0] d;
        logic        wr;
        for (int k = 0; k < len; k++) begin
            if (k > 0) check("mid_done", 32'(src_done), 32'h0);
            ack_xfer(32'h0, d, wr);
            check("data_word", d, base + 32'(k));
            check("data_wr", 32'(wr), 32'd1);
        end
        check("done_pulse", 32'(src_done), 32'(4'b1 << s));
        check("grant_clr", 32'(src_grant), 32'h0);
        check("wr_back0", 32'(bridge_wr), 32'h0);
        @(negedge clk);
        check("done_once", 32'(src_done), 32'h0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        logic        wr;
        logic [3:0]  ids [4];
        int          unstable;

        tbl[0] = '{src: 1, len: 8'd2,   base: 32'hDEAD_0000, hdr: 32'hA501_0002};
        tbl[1] = '{src: 2, len: 8'd0,   base: 32'h0000_2222, hdr: 32'hA502_0000};
        tbl[2] = '{src: 3, len: 8'd3,   base: 32'hBEEF_0010, hdr: 32'hA503_0003};
        tbl[3] = '{src: 0, len: 8'd1,   base: 32'h1234_5678, hdr: 32'hA500_0001};
        tbl[4] = '{src: 3, len: 8'd255, base: 32'hC0DE_0000, hdr: 32'hA503_00FF};

        reset_n    = 1'b0;
        src_req    = '0;
        src_len    = '0;
        bridge_q   = '0;
        bridge_ack = 1'b0;
        for (int s = 0; s < 4; s++) base_arr[s] = '0;
        repeat (3) @(negedge clk);
        check("rst_req",   32'(bridge_req), 32'h0);
        check("rst_wr",    32'(bridge_wr),  32'h0);
        check("rst_grant", 32'(src_grant),  32'h0);
        check("rst_d",     bridge_d,        32'h0);
        check("rst_cmdq",  cmd_q,           32'h0);
        check("rst_cmdv",  32'(cmd_valid),  32'h0);
        reset_n = 1'b1;

        // Idle command poll
        ack_xfer(32'h0102_0304, d, wr);
        check("poll_wr", 32'(wr), 32'h0);
        check("poll_cmdv", 32'(cmd_valid), 32'h1);
        check("poll_cmdq", cmd_q, 32'h0102_0304);
        check("poll_gap", 32'(bridge_req), 32'h0);
        @(negedge clk);
        check("poll_cmdv_once", 32'(cmd_valid), 32'h0);
        check("poll_req_back", 32'(bridge_req), 32'h1);
        check("poll_wr_still0", 32'(bridge_wr), 32'h0);

        // Single packets; src_req drops right after the header is accepted
        for (int t = 0; t < 5; t++) begin
            src_len = 32'h7777_7777;
            src_len[tbl[t].src*8 +: 8] = tbl[t].len;
            base_arr[tbl[t].src] = tbl[t].base;
            src_req = 4'b1 << tbl[t].src;
            get_header(tbl[t].hdr);
            src_req = '0;
            src_len = '0;
            if (tbl[t].len == 8'd0) begin
                check("z_done", 32'(src_done), 32'(4'b1 << tbl[t].src));
                check("z_wr", 32'(bridge_wr), 32'h0);
                @(negedge clk);
                check("z_done_once", 32'(src_done), 32'h0);
            end else begin
                check("hdr_no_done", 32'(src_done), 32'h0);
                send_data(tbl[t].src, int'(tbl[t].len), tbl[t].base);
            end
        end

        // Round-robin between two continuous requesters
        src_req = 4'b1001;
        src_len = 32'h0100_0001;
        base_arr[0] = 32'h0000_0100;
        base_arr[3] = 32'h0000_0300;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            wr = 1'b0;
            for (int k = 0; k < 6 && !wr; k++) ack_xfer(32'h0, d, wr);
            ids[p] = d[19:16];
            ack_xfer(32'h0, d, wr);
            if (p == 3) src_req = '0;
        end
        check("rr_0", 32'(ids[0]), 32'd0);
        check("rr_1", 32'(ids[1]), 32'd3);
        check("rr_2", 32'(ids[2]), 32'd0);
        check("rr_3", 32'(ids[3]), 32'd3);

        // Reset during DATA
        src_len = 32'h0003_0000;
        base_arr[2] = 32'h0000_2000;
        src_req = 4'b0100;
        get_header(32'hA502_0003);
        src_req = '0;
        ack_xfer(32'h0, d, wr);
        check("pre_rst_idx", 32'(src_idx), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("mrst_grant", 32'(src_grant), 32'h0);
        check("mrst_req",   32'(bridge_req), 32'h0);
        check("mrst_wr",    32'(bridge_wr), 32'h0);
        check("mrst_d",     bridge_d, 32'h0);
        check("mrst_idx",   32'(src_idx), 32'h0);
        check("mrst_done",  32'(src_done), 32'h0);
        unstable = 0;
        repeat (10) begin
            @(negedge clk);
            if (src_done !== 4'h0 || src_grant !== 4'h0 || bridge_wr !== 1'b0) unstable++;
        end
        check("mrst_quiet", 32'(unstable), 32'h0);

        // Stall during DATA
        src_len = 32'h0000_0300;
        base_arr[1] = 32'h0000_5000;
        src_req = 4'b0010;
        get_header(32'hA501_0003);
        src_req = '0;
        ack_xfer(32'h0, d, wr);
        check("stall_w0", d, 32'h0000_5000);
        @(negedge clk);
        unstable = 0;
        repeat (50) begin
            if (bridge_d !== 32'h0000_5001 || bridge_wr !== 1'b1 || bridge_req !== 1'b1 || src_idx !== 8'd1)
                unstable++;
            @(negedge clk);
        end
        check("stall_stable", 32'(unstable), 32'h0);
        ack_xfer(32'h0, d, wr);
        check("stall_w1", d, 32'h0000_5001);
        ack_xfer(32'h0, d, wr);
        check("stall_w2", d, 32'h0000_5002);
        check("stall_done", 32'(src_done), 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
